// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared FSM state and sort phase types for the sort engine
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SORT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } phase_t;

endpackage

// File: rtl/sort_cmp_swap.sv
// rtl/sort_cmp_swap.sv - single compare-exchange cell for one adjacent pair
module sort_cmp_swap #(
  parameter int DATA_W = 32,
  parameter int SIGNED = 0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              desc,
  output logic [DATA_W-1:0] lo_out,
  output logic [DATA_W-1:0] hi_out,
  output logic              swapped
);

  logic a_gt_b;
  logic b_gt_a;

  // Strict compares only, so equal keys never move and order stays stable.
  generate
    if (SIGNED != 0) begin : g_signed
      assign a_gt_b = $signed(a) > $signed(b);
      assign b_gt_a = $signed(b) > $signed(a);
    end else begin : g_unsigned
      assign a_gt_b = a > b;
      assign b_gt_a = b > a;
    end
  endgenerate

  // lo_out lands on the lower index, hi_out on the higher index.
  assign swapped = desc ? b_gt_a : a_gt_b;
  assign lo_out  = swapped ? b : a;
  assign hi_out  = swapped ? a : b;

endmodule

// File: rtl/sort_engine_param.sv
// rtl/sort_engine_param.sv - odd-even transposition sort engine with load and drain streams
module sort_engine_param
  import sort_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  parameter  int SIGNED = 0,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              cfg_desc,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err_len
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int NPAIR  = DEPTH - 1;
  localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t            state;
  phase_t            phase;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  widx;
  logic [CNT_W-1:0]  ridx;
  logic [CNT_W-1:0]  phase_cnt;
  logic              desc_q;
  logic              prev_zero;

  logic [DATA_W-1:0] mem      [DEPTH];
  logic [DATA_W-1:0] mem_next [DEPTH];
  logic [DATA_W-1:0] lo       [NPAIR];
  logic [DATA_W-1:0] hi       [NPAIR];
  logic [NPAIR-1:0]  swp;
  logic [NPAIR-1:0]  active;

  logic              any_swap;
  logic              sort_done;
  logic              len_ok;
  logic [ADDR_W-1:0] widx_a;
  logic [ADDR_W-1:0] ridx_a;

  assign widx_a    = widx[ADDR_W-1:0];
  assign ridx_a    = ridx[ADDR_W-1:0];
  assign len_ok    = (cfg_len != '0) && (cfg_len <= DEPTH_L);
  assign any_swap  = |(swp & active);
  // Odd-even transposition is complete after len phases; two quiet phases in
  // a row (one even, one odd) also prove every adjacent pair is in order.
  assign sort_done = ((phase_cnt + ONE) == len_q) || (!any_swap && prev_zero);
  assign out_data  = out_valid ? mem[ridx_a] : '0;

  // One compare-exchange cell per adjacent pair; the phase picks which half is live.
  generate
    for (genvar i = 0; i < NPAIR; i++) begin : g_pair
      localparam logic [CNT_W-1:0] RIGHT    = CNT_W'(i + 1);
      localparam bit               ODD_PAIR = (i % 2) == 1;

      sort_cmp_swap #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
      ) u_cmp_swap (
        .a       (mem[i]),
        .b       (mem[i+1]),
        .desc    (desc_q),
        .lo_out  (lo[i]),
        .hi_out  (hi[i]),
        .swapped (swp[i])
      );

      assign active[i] = (state == SORT) && (ODD_PAIR == (phase == ODD)) && (RIGHT < len_q);
    end

    // Live pairs in one phase never overlap, so each slot has at most one source.
    for (genvar k = 0; k < DEPTH; k++) begin : g_elem
      if (k == 0) begin : g_first
        assign mem_next[k] = active[0] ? lo[0] : mem[0];
      end else if (k == DEPTH - 1) begin : g_final
        assign mem_next[k] = active[k-1] ? hi[k-1] : mem[k];
      end else begin : g_mid
        assign mem_next[k] = active[k] ? lo[k] : (active[k-1] ? hi[k-1] : mem[k]);
      end
    end
  endgenerate

  // Element storage: written by the load stream, then rewritten every sort phase.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) begin
      mem[widx_a] <= in_data;
    end else if (state == SORT) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= mem_next[k];
      end
    end
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      phase     <= EVEN;
      len_q     <= '0;
      desc_q    <= 1'b0;
      widx      <= '0;
      ridx      <= '0;
      phase_cnt <= '0;
      prev_zero <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      err_len <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_q    <= cfg_len;
              desc_q   <= cfg_desc;
              widx     <= '0;
              state    <= LOAD;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end else begin
              err_len <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (in_valid) begin
            widx <= widx + ONE;
            if (widx == (len_q - ONE)) begin
              state     <= SORT;
              in_ready  <= 1'b0;
              phase     <= EVEN;
              phase_cnt <= '0;
              prev_zero <= 1'b0;
            end
          end
        end

        SORT: begin
          phase_cnt <= phase_cnt + ONE;
          phase     <= (phase == EVEN) ? ODD : EVEN;
          prev_zero <= !any_swap;
          if (sort_done) begin
            state     <= DRAIN;
            ridx      <= '0;
            out_valid <= 1'b1;
            out_last  <= (len_q == ONE);
          end
        end

        DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              ridx      <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end else begin
              ridx     <= ridx + ONE;
              out_last <= ((ridx + ONE) == (len_q - ONE));
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_engine_param.sv
// tb/tb_sort_engine_param.sv - directed self-checking bench for sort_engine_param
module tb_sort_engine_param;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  cfg_len;
  logic        cfg_desc;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        err_len;

  logic        s_start;
  logic [2:0]  s_cfg_len;
  logic        s_cfg_desc;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [7:0]  s_in_data;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [7:0]  s_out_data;
  logic        s_out_last;
  logic        s_busy;
  logic        s_err_len;

  int          errors;
  int          checks;
  int          loaded;
  int          got_n;
  int          stall_err;
  logic [31:0] vals     [8];
  logic [31:0] got_data [8];
  logic        got_last [8];

  sort_engine_param #(.DATA_W(32), .DEPTH(8), .SIGNED(0)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cfg_len   (cfg_len),
    .cfg_desc  (cfg_desc),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .err_len   (err_len)
  );

  sort_engine_param #(.DATA_W(8), .DEPTH(4), .SIGNED(1)) u_sdut (
    .clk       (clk),
    .reset     (reset),
    .start     (s_start),
    .cfg_len   (s_cfg_len),
    .cfg_desc  (s_cfg_desc),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .out_last  (s_out_last),
    .busy      (s_busy),
    .err_len   (s_err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_job(input int len, input bit desc);
    start    = 1'b1;
    cfg_len  = 4'(len);
    cfg_desc = desc;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic load_job(input int n);
    int g;
    loaded = 0;
    for (int i = 0; i < n; i++) begin
      in_data  = vals[i];
      in_valid = 1'b1;
      g = 0;
      while (!in_ready && g < 20) begin
        @(posedge clk); #1;
        g++;
      end
      if (in_ready) begin
        @(posedge clk); #1;
        loaded++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_job(input int n, input bit toggle);
    int          cyc;
    bit          rdy;
    bit          hold;
    logic [31:0] hd;
    logic        hl;
    got_n     = 0;
    stall_err = 0;
    cyc       = 0;
    rdy       = !toggle;
    hd        = '0;
    hl        = 1'b0;
    while (got_n < n && got_n < 8 && cyc < 200) begin
      out_ready = rdy;
      hold      = 1'b0;
      if (out_valid) begin
        if (rdy) begin
          got_data[got_n] = out_data;
          got_last[got_n] = out_last;
          got_n++;
        end else begin
          hd   = out_data;
          hl   = out_last;
          hold = 1'b1;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (hold && (out_data !== hd || out_last !== hl || out_valid !== 1'b1)) stall_err++;
      if (toggle) rdy = !rdy;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL reset_err_len: got %b expected 0", err_len); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ascending;
    logic [31:0] exp [8];
    vals = '{32'd3, 32'd1, 32'd4, 32'd1, 32'd5, 32'd0, 32'd0, 32'd0};
    exp  = '{32'd1, 32'd1, 32'd3, 32'd4, 32'd5, 32'd0, 32'd0, 32'd0};
    start_job(5, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL asc_busy: got %b expected 1", busy); end
    load_job(5);
    drain_job(5, 1'b0);
    checks++; if (got_n !== 5) begin errors++; $display("FAIL asc_count: got %0d expected 5", got_n); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (got_data[i] !== exp[i]) begin errors++; $display("FAIL asc_data[%0d]: got %0d expected %0d", i, got_data[i], exp[i]); end
      checks++; if (got_last[i] !== (i == 4)) begin errors++; $display("FAIL asc_last[%0d]: got %b expected %b", i, got_last[i], (i == 4)); end
    end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL asc_idle: got valid=%b busy=%b expected 0 0", out_valid, busy); end
  endtask

  task automatic test_descending;
    logic [31:0] exp [8];
    vals = '{32'd2, 32'd9, 32'd7, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0};
    exp  = '{32'd9, 32'd9, 32'd7, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0};
    start_job(4, 1'b1);
    load_job(4);
    drain_job(4, 1'b0);
    checks++; if (got_n !== 4) begin errors++; $display("FAIL desc_count: got %0d expected 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_data[i] !== exp[i]) begin errors++; $display("FAIL desc_data[%0d]: got %0d expected %0d", i, got_data[i], exp[i]); end
      checks++; if (got_last[i] !== (i == 3)) begin errors++; $display("FAIL desc_last[%0d]: got %b expected %b", i, got_last[i], (i == 3)); end
    end
  endtask

  task automatic test_early_exit;
    int cnt;
    for (int i = 0; i < 8; i++) vals[i] = 32'(i);
    start_job(8, 1'b0);
    load_job(8);
    checks++; if (loaded !== 8) begin errors++; $display("FAIL early_loaded: got %0d expected 8", loaded); end
    cnt = 0;
    while (!out_valid && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    checks++; if (cnt !== 2) begin errors++; $display("FAIL early_sort_cycles: got %0d expected 2", cnt); end
    drain_job(8, 1'b0);
    checks++; if (got_n !== 8) begin errors++; $display("FAIL early_count: got %0d expected 8", got_n); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got_data[i] !== 32'(i)) begin errors++; $display("FAIL early_data[%0d]: got %0d expected %0d", i, got_data[i], i); end
    end
    checks++; if (got_last[7] !== 1'b1 || got_last[6] !== 1'b0) begin errors++; $display("FAIL early_last: got %b%b expected 01", got_last[6], got_last[7]); end
  endtask

  task automatic test_reverse_full;
    for (int i = 0; i < 8; i++) vals[i] = 32'(7 - i);
    start_job(8, 1'b0);
    load_job(8);
    drain_job(8, 1'b0);
    checks++; if (got_n !== 8) begin errors++; $display("FAIL rev_count: got %0d expected 8", got_n); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got_data[i] !== 32'(i)) begin errors++; $display("FAIL rev_data[%0d]: got %0d expected %0d", i, got_data[i], i); end
    end
  endtask

  task automatic test_len_one;
    int cnt;
    vals[0] = 32'd42;
    start_job(1, 1'b0);
    load_job(1);
    cnt = 0;
    while (!out_valid && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    checks++; if (cnt !== 1) begin errors++; $display("FAIL len1_sort_cycles: got %0d expected 1", cnt); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL len1_last: got %b expected 1", out_last); end
    drain_job(1, 1'b0);
    checks++; if (got_data[0] !== 32'd42) begin errors++; $display("FAIL len1_data: got %0d expected 42", got_data[0]); end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp [8];
    vals = '{32'd6, 32'd3, 32'd8, 32'd3, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0};
    exp  = '{32'd1, 32'd3, 32'd3, 32'd6, 32'd8, 32'hFFFF_FFFF, 32'd0, 32'd0};
    start_job(6, 1'b0);
    load_job(6);
    drain_job(6, 1'b1);
    checks++; if (got_n !== 6) begin errors++; $display("FAIL bp_count: got %0d expected 6", got_n); end
    checks++; if (stall_err !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable stalls expected 0", stall_err); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (got_data[i] !== exp[i]) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, got_data[i], exp[i]); end
      checks++; if (got_last[i] !== (i == 5)) begin errors++; $display("FAIL bp_last[%0d]: got %b expected %b", i, got_last[i], (i == 5)); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_len_errors;
    int bad [2];
    bad = '{0, 9};
    for (int j = 0; j < 2; j++) begin
      start_job(bad[j], 1'b0);
      checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL err_pulse[%0d]: got %b expected 1", bad[j], err_len); end
      checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL err_idle[%0d]: got ready=%b busy=%b expected 0 0", bad[j], in_ready, busy); end
      @(posedge clk); #1;
      checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL err_one_cycle[%0d]: got %b expected 0", bad[j], err_len); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL err_no_load[%0d]: got %b expected 0", bad[j], in_ready); end
    end
  endtask

  task automatic test_reset_mid_sort;
    for (int i = 0; i < 8; i++) vals[i] = 32'(7 - i);
    start_job(8, 1'b0);
    load_job(8);
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midsort_state: got busy=%b valid=%b expected 1 0", busy, out_valid); end
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midsort_busy: got %b expected 0", busy); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL midsort_hs: got valid=%b ready=%b expected 0 0", out_valid, in_ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    vals[0] = 32'd1;
    vals[1] = 32'd2;
    start_job(2, 1'b1);
    load_job(2);
    drain_job(2, 1'b0);
    checks++; if (got_n !== 2 || got_data[0] !== 32'd2 || got_data[1] !== 32'd1) begin errors++; $display("FAIL post_reset_job: got n=%0d %0d,%0d expected 2 2,1", got_n, got_data[0], got_data[1]); end
    checks++; if (got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin errors++; $display("FAIL post_reset_last: got %b%b expected 01", got_last[0], got_last[1]); end
  endtask

  task automatic test_signed;
    logic [7:0] sv  [3];
    logic [7:0] exp [3];
    logic [7:0] got [3];
    int         g;
    int         n;
    sv  = '{8'hFF, 8'h05, 8'h00};
    exp = '{8'hFF, 8'h00, 8'h05};
    got = '{8'h00, 8'h00, 8'h00};
    s_start    = 1'b1;
    s_cfg_len  = 3'd3;
    s_cfg_desc = 1'b0;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_in_data  = sv[i];
      s_in_valid = 1'b1;
      g = 0;
      while (!s_in_ready && g < 20) begin
        @(posedge clk); #1;
        g++;
      end
      @(posedge clk); #1;
    end
    s_in_valid  = 1'b0;
    s_out_ready = 1'b1;
    n = 0;
    g = 0;
    while (n < 3 && g < 100) begin
      if (s_out_valid) begin
        got[n] = s_out_data;
        n++;
      end
      @(posedge clk); #1;
      g++;
    end
    s_out_ready = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("FAIL signed_count: got %0d expected 3", n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL signed_data[%0d]: got %h expected %h", i, got[i], exp[i]); end
    end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    reset       = 1'b0;
    start       = 1'b0;
    cfg_len     = '0;
    cfg_desc    = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    s_start     = 1'b0;
    s_cfg_len   = '0;
    s_cfg_desc  = 1'b0;
    s_in_valid  = 1'b0;
    s_in_data   = '0;
    s_out_ready = 1'b0;

    test_reset;
    test_ascending;
    test_descending;
    test_early_exit;
    test_reverse_full;
    test_len_one;
    test_backpressure;
    test_len_errors;
    test_reset_mid_sort;
    test_signed;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sort_engine_param.md
SORT_ENGINE_PARAM -- requirements
Module: sort_engine_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, element width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, maximum elements per job; legal range 2..1024.
REQ-003 SHALL have parameter SIGNED, default 0; 1 selects two's-complement compare, 0 selects unsigned compare.
REQ-004 SHALL have derived localparam CNT_W = clog2(DEPTH+1).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  job request, sampled in IDLE only.
REQ-008 SHALL have port cfg_len  input  CNT_W  element count, sampled with start.
REQ-009 SHALL have port cfg_desc  input  1  1 = descending, 0 = ascending, sampled with start.
REQ-010 SHALL have port in_valid / in_ready / in_data  in/out/in  1/1/DATA_W  load stream.
REQ-011 SHALL have port out_valid / out_ready / out_data  out/in/out  1/1/DATA_W  result stream.
REQ-012 SHALL have port out_last  output  1  marks final result element.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port err_len  output  1  one-cycle pulse on rejected start.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, SORT, DRAIN.
REQ-016 IDLE: start with 1 <= cfg_len <= DEPTH latches len and dir and moves to LOAD next cycle; otherwise err_len pulses one cycle and the FSM stays in IDLE.
REQ-017 start outside IDLE SHALL be ignored.
REQ-018 LOAD: in_ready=1; each in_valid&&in_ready writes in_data to mem[widx], widx++; the len-th handshake moves to SORT next cycle.
REQ-019 SORT: one phase per cycle, starting with an even phase and alternating; even phase compare-exchanges pairs (0,1),(2,3)...; odd phase (1,2),(3,4)...; only pairs with both indices < len take part.
REQ-020 Swap SHALL occur only when strictly out of order (asc: a>b, desc: a<b); equal elements never swap, so the sort is stable.
REQ-021 SORT SHALL exit to DRAIN after len phases, or earlier after two consecutive phases with zero swaps; len=1 exits after one cycle.
REQ-022 DRAIN: out_valid=1, out_data=mem[ridx]; ridx advances on out_valid&&out_ready; out_last=1 when ridx==len-1; the last handshake moves to IDLE.
REQ-023 out_data and out_last SHALL hold stable while out_valid && !out_ready.
REQ-024 in_ready SHALL be 0 outside LOAD; out_valid SHALL be 0 outside DRAIN.
REQ-025 Comparison width SHALL be exactly DATA_W, with no truncation or extension beyond sign per SIGNED.

Reset
REQ-026 While reset=0: FSM=IDLE; widx, ridx, phase counter, and swap history cleared; in_ready, out_valid, out_last, busy, err_len all 0; out_data 0.
REQ-027 Reset SHALL act immediately, mid-job included; mem contents are not cleared and are not observable afterwards.

Structure
REQ-028 Package sort_pkg SHALL hold the state typedef (IDLE/LOAD/SORT/DRAIN) and the phase enum (EVEN/ODD).
REQ-029 Sub-module sort_cmp_swap (DATA_W, SIGNED params; inputs a, b, desc; outputs lo_out, hi_out, swapped) SHALL be instantiated once per adjacent pair.

Verification
REQ-030 Ascending sort: DEPTH=8, len=5, asc, in 3,1,4,1,5 -> out 1,1,3,4,5; out_last only on 5.
REQ-031 Descending sort: len=4, desc, in 2,9,7,9 -> out 9,9,7,2.
REQ-032 Early exit: len=8, asc, in 0..7 -> SORT lasts exactly 2 cycles; out 0..7.
REQ-033 Backpressure: len=6, out_ready toggles every cycle -> no loss or duplication; out_data held while stalled.
REQ-034 Length errors and reset: start with cfg_len=0, then with cfg_len=DEPTH+1 -> err_len pulses each time, in_ready stays 0; reset asserted mid-SORT -> busy, out_valid, in_ready 0 immediately.
REQ-035 Signed compare: SIGNED=1, DATA_W=8, len=3, asc, in 0xFF,0x05,0x00 -> out 0xFF,0x00,0x05.
